// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch held as four BCD digits, advanced by edges of the divider's
// 1 Hz / 2 Hz square waves; supports run/pause, clear and a per-field adjust mode.
module stopwatch_counter #(
    parameter int MIN_LIMIT = 59,
    parameter int SEC_LIMIT = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_1hz,
    input  logic       clk_2hz,
    input  logic       pause_p,
    input  logic       clear_p,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] blank,
    output logic       running,
    output logic       wrap_p
);

    localparam logic [3:0] MIN_LIM_T = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] MIN_LIM_O = 4'(MIN_LIMIT % 10);
    localparam logic [3:0] SEC_LIM_T = 4'(SEC_LIMIT / 10);
    localparam logic [3:0] SEC_LIM_O = 4'(SEC_LIMIT % 10);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       saved_run;
    logic       saved_run_nxt;
    logic       prev_1hz;
    logic       prev_2hz;
    logic       sel_prev;
    logic       tick1;
    logic       tick2;
    logic [8:0] sec_inc;
    logic [8:0] min_inc;
    logic [3:0] min_tens_nxt;
    logic [3:0] min_ones_nxt;
    logic [3:0] sec_tens_nxt;
    logic [3:0] sec_ones_nxt;
    logic [1:0] blank_nxt;
    logic       wrap_nxt;

    // Two-digit BCD increment against a BCD limit; result is {wrapped, tens, ones}.
    // Anything at or above the limit wraps, so the field can never escape 0..limit.
    function automatic logic [8:0] bcd_inc(input logic [3:0] tens,
                                           input logic [3:0] ones,
                                           input logic [3:0] lim_t,
                                           input logic [3:0] lim_o);
        logic [8:0] r;
        if ((tens > lim_t) || ((tens == lim_t) && (ones >= lim_o))) begin
            r = {1'b1, 4'd0, 4'd0};
        end else if (ones >= 4'd9) begin
            r = {1'b0, tens + 4'd1, 4'd0};
        end else begin
            r = {1'b0, tens, ones + 4'd1};
        end
        return r;
    endfunction

    assign tick1   = clk_1hz & ~prev_1hz;
    assign tick2   = clk_2hz & ~prev_2hz;
    assign sec_inc = bcd_inc(sec_tens, sec_ones, SEC_LIM_T, SEC_LIM_O);
    assign min_inc = bcd_inc(min_tens, min_ones, MIN_LIM_T, MIN_LIM_O);
    assign running = (state == ST_RUN);

    always_comb begin
        state_nxt     = state;
        saved_run_nxt = saved_run;
        case (state)
            ST_RUN: begin
                if (adj) begin
                    state_nxt     = ST_ADJUST;
                    saved_run_nxt = 1'b1;
                end else if (pause_p) begin
                    state_nxt = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (adj) begin
                    state_nxt     = ST_ADJUST;
                    saved_run_nxt = 1'b0;
                end else if (pause_p) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_ADJUST: begin
                if (!adj) begin
                    state_nxt = saved_run ? ST_RUN : ST_PAUSED;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        min_tens_nxt = min_tens;
        min_ones_nxt = min_ones;
        sec_tens_nxt = sec_tens;
        sec_ones_nxt = sec_ones;
        wrap_nxt     = 1'b0;
        blank_nxt    = 2'b00;

        // Blink mask only lives while we stay in adjust, so it is already 00 on exit.
        if ((state == ST_ADJUST) && (state_nxt == ST_ADJUST)) begin
            blank_nxt = blank;
            if (sel != sel_prev) begin
                blank_nxt = 2'b00;
            end else if (tick2) begin
                blank_nxt = sel ? {~blank[1], 1'b0} : {1'b0, ~blank[0]};
            end
        end

        if (clear_p) begin
            min_tens_nxt = 4'd0;
            min_ones_nxt = 4'd0;
            sec_tens_nxt = 4'd0;
            sec_ones_nxt = 4'd0;
        end else if ((state == ST_RUN) && tick1) begin
            sec_tens_nxt = sec_inc[7:4];
            sec_ones_nxt = sec_inc[3:0];
            if (sec_inc[8]) begin
                min_tens_nxt = min_inc[7:4];
                min_ones_nxt = min_inc[3:0];
                wrap_nxt     = min_inc[8];
            end
        end else if ((state == ST_ADJUST) && tick2) begin
            // Adjust wraps each field on its own, with no carry between them.
            if (sel) begin
                min_tens_nxt = min_inc[7:4];
                min_ones_nxt = min_inc[3:0];
            end else begin
                sec_tens_nxt = sec_inc[7:4];
                sec_ones_nxt = sec_inc[3:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            saved_run <= 1'b1;
            prev_1hz  <= 1'b1;
            prev_2hz  <= 1'b1;
            sel_prev  <= 1'b0;
            min_tens  <= 4'd0;
            min_ones  <= 4'd0;
            sec_tens  <= 4'd0;
            sec_ones  <= 4'd0;
            blank     <= 2'b00;
            wrap_p    <= 1'b0;
        end else begin
            state     <= state_nxt;
            saved_run <= saved_run_nxt;
            prev_1hz  <= clk_1hz;
            prev_2hz  <= clk_2hz;
            sel_prev  <= sel;
            min_tens  <= min_tens_nxt;
            min_ones  <= min_ones_nxt;
            sec_tens  <= sec_tens_nxt;
            sec_ones  <= sec_ones_nxt;
            blank     <= blank_nxt;
            wrap_p    <= wrap_nxt;
        end
    end

endmodule
